// File: rtl/dds_pkg.sv
// Shared widths, constants and the modulation-mode encoding for the DDS sample source.
// Also holds the elaboration-time quarter-wave sine generator used to fill the LUT.
package dds_pkg;

   localparam int PHASE_W  = 32;
   localparam int SAMPLE_W = 12;
   localparam int LUT_AW   = 8;

   localparam logic [SAMPLE_W-1:0] MIDSCALE  = 12'h800;
   localparam logic [4:0]          LFSR_SEED = 5'b00001;

   typedef enum logic [1:0] {
      MOD_NONE = 2'd0,
      MOD_ASK  = 2'd1,
      MOD_BPSK = 2'd2,
      MOD_FSK  = 2'd3
   } mod_t;

   // round(2047 * sin(pi*(2*idx+1)/1024)) in Q30 fixed point (Taylor series to x^19).
   // Only ever evaluated on constants, so it folds away to table contents.
   function automatic logic [SAMPLE_W-2:0] quarter_sine(input int idx);
      longint x;
      longint x2;
      longint term;
      longint acc;
      x    = (64'sd3373259426 * longint'(2 * idx + 1)) >>> 10;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int k = 1; k <= 9; k++) begin
         term = (term * x2) >>> 30;
         term = term / longint'((2 * k) * (2 * k + 1));
         acc  = (k % 2 == 1) ? (acc - term) : (acc + term);
      end
      return 11'((acc * 64'sd2047 + (64'sd1 <<< 29)) >>> 30);
   endfunction

endpackage

// File: rtl/dds_modulator_if.sv
// Control and sample bus of the DDS modulator; master drives controls, slave is the DDS.
// sample_valid is a level qualifier with no ready: once high, data_out carries a new sample every clk.
interface dds_modulator_if;
   import dds_pkg::*;

   logic                enable;
   logic [PHASE_W-1:0]  tune_word_0;
   logic [PHASE_W-1:0]  tune_word_1;
   mod_t                mod_sel;
   logic                lfsr_tick;
   logic [SAMPLE_W-1:0] data_out;
   logic                lfsr_bit;
   logic                sample_valid;

   modport master (
      output enable, tune_word_0, tune_word_1, mod_sel, lfsr_tick,
      input  data_out, lfsr_bit, sample_valid
   );

   modport slave (
      input  enable, tune_word_0, tune_word_1, mod_sel, lfsr_tick,
      output data_out, lfsr_bit, sample_valid
   );

endinterface

// File: rtl/sine_quarter_lut.sv
// Combinational quarter-wave sine magnitude ROM, 256 entries of 11 bits.
module sine_quarter_lut
   import dds_pkg::*;
(
   input  logic [LUT_AW-1:0]   addr,
   output logic [SAMPLE_W-2:0] mag
);

   logic [SAMPLE_W-2:0] rom [2**LUT_AW];

   // Each entry is a localparam, so the contents are fixed at elaboration.
   for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
      localparam logic [SAMPLE_W-2:0] MAG = quarter_sine(g);
      assign rom[g] = MAG;
   end

   assign mag = rom[addr];

endmodule

// File: rtl/dds_modulator.sv
// DDS sample source: phase accumulator, 5-bit LFSR data source and a 3-stage
// quarter-wave synthesis pipeline with none/ASK/BPSK/FSK modulation at the output.
module dds_modulator
   import dds_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   dds_modulator_if.slave bus
);

   logic [PHASE_W-1:0]  phase;
   logic [PHASE_W-1:0]  tw;
   logic [4:0]          lfsr;
   logic [1:0]          s1_quad;
   logic [LUT_AW-1:0]   s1_idx;
   logic [SAMPLE_W-2:0] lut_mag;
   logic [SAMPLE_W-2:0] s2_mag;
   logic                s2_sign;
   logic [2:0]          valid_sr;
   logic [SAMPLE_W-1:0] s3_sample;
   logic [SAMPLE_W-1:0] s3_mod;

   assign bus.lfsr_bit     = lfsr[0];
   assign bus.sample_valid = valid_sr[2];

   // FSK picks the increment from the bit as it stands before any tick on this edge.
   assign tw = (bus.mod_sel == MOD_FSK && lfsr[0]) ? bus.tune_word_1 : bus.tune_word_0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (bus.enable) begin
         phase <= phase + tw;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else if (bus.lfsr_tick) begin
         lfsr <= {lfsr[0] ^ lfsr[2], lfsr[4:1]};
      end
   end

   sine_quarter_lut u_lut (
      .addr (s1_idx),
      .mag  (lut_mag)
   );

   always_comb begin
      s3_sample = s2_sign ? (12'h7FF - {1'b0, s2_mag}) : (MIDSCALE + {1'b0, s2_mag});
      s3_mod    = s3_sample;
      unique case (bus.mod_sel)
         MOD_ASK:  if (!lfsr[0]) s3_mod = MIDSCALE;
         MOD_BPSK: if (!lfsr[0]) s3_mod = ~s3_sample;
         default:  ;
      endcase
   end

   // Odd quadrants read the table backwards; the upper half-cycle flips the sign.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_quad      <= '0;
         s1_idx       <= '0;
         s2_mag       <= '0;
         s2_sign      <= 1'b0;
         valid_sr     <= '0;
         bus.data_out <= MIDSCALE;
      end else begin
         s1_quad      <= phase[PHASE_W-1 -: 2];
         s1_idx       <= phase[PHASE_W-2] ? ~phase[PHASE_W-3 -: LUT_AW]
                                          :  phase[PHASE_W-3 -: LUT_AW];
         s2_mag       <= lut_mag;
         s2_sign      <= s1_quad[1];
         valid_sr     <= {valid_sr[1:0], 1'b1};
         bus.data_out <= valid_sr[1] ? s3_mod : MIDSCALE;
      end
   end

endmodule

// File: tb/tb_dds_modulator.sv
// Self-checking bench for dds_modulator: directed scenarios plus random traffic
// against a sine/phase reference model built from real arithmetic.
module tb_dds_modulator;
   import dds_pkg::*;

   localparam real PI = 3.14159265358979323846;

   logic clk;
   logic reset;

   dds_modulator_if bus ();

   dds_modulator dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_phase;
   int          m_lfsr;
   logic [11:0] exp_q[$];
   logic [11:0] exp_data;
   logic        exp_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] ref_sample(input logic [31:0] ph);
      longint unsigned p;
      int quad;
      int pos;
      int a;
      p    = 64'(ph);
      quad = int'(p / 64'h4000_0000);
      pos  = int'((p % 64'h4000_0000) / 64'h40_0000);
      if (quad % 2 == 1) pos = 255 - pos;
      a = $rtoi(2047.0 * $sin(PI * real'(2 * pos + 1) / 1024.0) + 0.5);
      return (quad >= 2) ? 12'(2047 - a) : 12'(2048 + a);
   endfunction

   function automatic logic [11:0] ref_mod(input logic [11:0] s, input mod_t m, input int b);
      if (m == MOD_ASK && b == 0) return 12'h800;
      if (m == MOD_BPSK && b == 0) return 12'(4095 - int'(s));
      return s;
   endfunction

   function automatic int lfsr_next(input int v);
      return (v >> 1) + 16 * ((v ^ (v >> 2)) & 1);
   endfunction

   task automatic model_reset();
      m_phase   = '0;
      m_lfsr    = 1;
      exp_q.delete();
      exp_valid = 1'b0;
      exp_data  = 12'h800;
   endtask

   task automatic model_edge();
      logic [11:0] s;
      exp_q.push_back(ref_sample(m_phase));
      if (exp_q.size() == 3) begin
         s         = exp_q.pop_front();
         exp_valid = 1'b1;
         exp_data  = ref_mod(s, bus.mod_sel, m_lfsr % 2);
      end else begin
         exp_data = 12'h800;
      end
      if (bus.enable)
         m_phase = m_phase + ((bus.mod_sel == MOD_FSK && m_lfsr % 2 == 1) ? bus.tune_word_1
                                                                          : bus.tune_word_0);
      if (bus.lfsr_tick) m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("data_out", 32'(bus.data_out), 32'(exp_data));
      check("sample_valid", 32'(bus.sample_valid), 32'(exp_valid));
      check("lfsr_bit", 32'(bus.lfsr_bit), m_lfsr % 2);
   endtask

   task automatic apply_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_data", 32'(bus.data_out), 32'h800);
      check("rst_valid", 32'(bus.sample_valid), 0);
      check("rst_bit", 32'(bus.lfsr_bit), 1);
      bus.lfsr_tick = 1'b1;
      bus.enable    = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      reset         = 1'b0;
      bus.lfsr_tick = 1'b0;
   endtask

   task automatic set_inputs(input logic en, input mod_t m, input logic [31:0] t0, input logic [31:0] t1);
      bus.enable      = en;
      bus.mod_sel     = m;
      bus.tune_word_0 = t0;
      bus.tune_word_1 = t1;
      bus.lfsr_tick   = 1'b0;
   endtask

   task automatic scn_basic(input string tag);
      logic [11:0] seq [4];
      seq = '{12'h806, 12'hFFF, 12'h7F9, 12'h000};
      apply_reset();
      set_inputs(1'b1, MOD_NONE, 32'h4000_0000, 32'h0);
      for (int k = 1; k <= 12; k++) begin
         cycle();
         check({tag, "_valid"}, 32'(bus.sample_valid), (k >= 3) ? 1 : 0);
         if (k >= 3) check({tag, "_data"}, 32'(bus.data_out), 32'(seq[(k - 3) % 4]));
      end
   endtask

   task automatic scn_hold();
      logic [11:0] seq [13];
      seq = '{12'h800, 12'h800, 12'h806, 12'hFFF, 12'h7F9, 12'h7F9, 12'h7F9,
              12'h7F9, 12'h7F9, 12'h7F9, 12'h000, 12'h806, 12'hFFF};
      apply_reset();
      set_inputs(1'b1, MOD_NONE, 32'h4000_0000, 32'h0);
      for (int k = 1; k <= 13; k++) begin
         bus.enable = !(k >= 3 && k <= 7);
         cycle();
         check("hold_data", 32'(bus.data_out), 32'(seq[k - 1]));
      end
   endtask

   task automatic scn_lfsr();
      logic [35:0] bits;
      int dups;
      apply_reset();
      set_inputs(1'b0, MOD_NONE, 32'h0, 32'h0);
      bits[0] = bus.lfsr_bit;
      for (int t = 1; t <= 35; t++) begin
         bus.lfsr_tick = 1'b1;
         cycle();
         bits[t] = bus.lfsr_bit;
         if (t == 1) check("lfsr_tick1_bit", 32'(bus.lfsr_bit), 0);
      end
      bus.lfsr_tick = 1'b0;
      check("lfsr_state1", 32'(bits[1 +: 5]), 32'h10);
      check("lfsr_state31", 32'(bits[31 +: 5]), 32'h01);
      dups = 0;
      for (int a = 0; a < 31; a++) begin
         if (bits[a +: 5] == 5'b0) dups++;
         for (int b = a + 1; b < 31; b++)
            if (bits[a +: 5] == bits[b +: 5]) dups++;
      end
      check("lfsr_unique", dups, 0);
   endtask

   task automatic scn_ask_bpsk();
      logic [11:0] bseq [4];
      bseq = '{12'h7F9, 12'h000, 12'h806, 12'hFFF};
      apply_reset();
      set_inputs(1'b1, MOD_ASK, 32'h4000_0000, 32'h0);
      for (int k = 1; k <= 20; k++) begin
         bus.lfsr_tick = (k == 1);
         bus.mod_sel   = (k <= 10) ? MOD_ASK : MOD_BPSK;
         cycle();
         if (k >= 3 && k <= 10) check("ask_zero", 32'(bus.data_out), 32'h800);
         if (k >= 11) check("bpsk_zero", 32'(bus.data_out), 32'(bseq[(k - 3) % 4]));
      end
   endtask

   task automatic scn_fsk();
      set_inputs(1'b1, MOD_FSK, 32'h0100_0000, 32'h0400_0000);
      for (int k = 1; k <= 80; k++) begin
         bus.lfsr_tick = (k % 5 == 0);
         cycle();
      end
   endtask

   task automatic scn_random(input int n);
      for (int k = 0; k < n; k++) begin
         bus.enable    = ($urandom_range(0, 9) != 0);
         bus.lfsr_tick = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 19) == 0) bus.mod_sel = mod_t'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) bus.tune_word_0 = $urandom;
         if ($urandom_range(0, 49) == 0) bus.tune_word_1 = $urandom;
         cycle();
      end
   endtask

   initial begin
      reset = 1'b0;
      set_inputs(1'b0, MOD_NONE, 32'h0, 32'h0);
      scn_basic("scn1");
      scn_hold();
      scn_lfsr();
      scn_ask_bpsk();
      scn_fsk();
      scn_random(1500);
      scn_basic("restart");
      scn_random(500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
